// File: rtl/token_window_counter.sv
// Counts tokens on a 1-bit stream over fixed WINDOW-cycle windows and queues each window's count in a FIFO.
// Optional macro TOKEN_WINDOW_DROP_CNT_EN adds a saturating counter of windows dropped on a full FIFO.
module token_window_counter #(
    parameter int WINDOW = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             out_ready,
`ifdef TOKEN_WINDOW_DROP_CNT_EN
    output logic [7:0]       drop_count,
`endif
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [7:0] CYC_LAST = 8'(WINDOW - 1);

    logic [7:0]       cyc_q, cyc_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0] mem_q [DEPTH];

    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             close_s;
    logic             push_s;
    logic [CNT_W-1:0] result_s;

    assign empty_s  = (wptr_q == rptr_q);
    assign full_s   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop_s    = !empty_s && out_ready;
    assign close_s  = (cyc_q == CYC_LAST);
    assign result_s = acc_q + {{(CNT_W-1){1'b0}}, a};
    // A full FIFO still accepts the result when its head leaves in the same cycle.
    assign push_s   = close_s && (!full_s || pop_s);

    assign out_valid = !empty_s;
    assign out_count = empty_s ? {CNT_W{1'b0}} : mem_q[rptr_q[AW-1:0]];

    // Next-state for window phase, accumulator and FIFO pointers.
    always_comb begin
        cyc_d  = cyc_q;
        acc_d  = acc_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (close_s) begin
            cyc_d = 8'd0;
            acc_d = {CNT_W{1'b0}};
        end else begin
            cyc_d = cyc_q + 8'd1;
            acc_d = result_s;
        end
        if (push_s) begin
            wptr_d = wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PW'(1);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // State registers; reset discards the partial window and flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= 8'd0;
            acc_q  <= {CNT_W{1'b0}};
            wptr_q <= {PW{1'b0}};
            rptr_q <= {PW{1'b0}};
        end else begin
            cyc_q  <= cyc_d;
            acc_q  <= acc_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // FIFO storage; contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_q[wptr_q[AW-1:0]] <= result_s;
        end
    end

`ifdef TOKEN_WINDOW_DROP_CNT_EN
    logic       drop_s;
    logic [7:0] drop_q, drop_d;

    assign drop_s     = close_s && full_s && !pop_s;
    assign drop_count = drop_q;

    // Saturating count of discarded windows.
    always_comb begin
        drop_d = drop_q;
        if (drop_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end
`endif

endmodule

// File: doc/token_window_counter.md
# token_window_counter

Downstream stage for the serial token path: consumes a 1-bit token stream (one token per cycle where the input is 1, e.g. the output of the token-halving stage) and counts tokens over fixed windows of WINDOW cycles. Each closed window's count is queued in a small FIFO and presented on a valid/ready output, so a slower consumer can read per-window token rates without stalling the serial stream.

## Interface
- WINDOW, default 8: cycles per window; legal range 2..255.
- DEPTH, default 4: result FIFO depth in entries; power of 2, minimum 2.
- CNT_W (localparam, derived): $clog2(WINDOW+1); 4 at default.
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- a  input  1  serial token stream; sampled every cycle.
- out_valid  output  1  FIFO holds at least one entry.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_count  output  CNT_W  head entry: tokens in that window, 0..WINDOW.
- drop_count  output  8  windows discarded because the FIFO was full; present only with TOKEN_WINDOW_DROP_CNT_EN.

## Operation
- Phase counter `cyc` runs 0..WINDOW-1 and wraps; accumulator `acc` (CNT_W bits) adds `a` each cycle.
- On the last cycle of a window (cyc == WINDOW-1), the window result is acc + a. Next cycle: acc = 0, cyc = 0.
- Push of the result:
  - FIFO not full: push.
  - FIFO full and pop in the same cycle: push accepted; occupancy unchanged.
  - FIFO full and no pop: result dropped.
- Pop happens when out_valid && out_ready; out_ready is ignored while out_valid = 0.
- out_count equals the FIFO head when out_valid = 1 and is 0 when the FIFO is empty.
- Zero-token windows are pushed as count 0, not skipped.
- FIFO uses read/write pointers of log2(DEPTH)+1 bits; full/empty come from pointer comparison, and pointers wrap naturally.
- Reset values: cyc = 0, acc = 0, FIFO empty, out_valid = 0, out_count = 0, drop_count = 0.
- Reset mid-operation discards the partial window and flushes all queued entries. The first window starts on the first cycle with rst = 0.

## Timing
- The first window covers cycles 0..WINDOW-1 after reset deassertion, where cycle 0 is the first cycle with rst low.
- Result latency: a window closing at edge t, if pushed into an empty FIFO, gives out_valid = 1 with its count in cycle t+1, i.e. 1 cycle after the last sampled token.
- No combinational path from `a` to any output. The only combinational path from out_ready is into the FIFO's internal pop/full logic.
- Back-to-back pops: one entry per cycle while out_ready = 1.
- Throughput: at most one push per WINDOW cycles.

## Configuration
- Macro: TOKEN_WINDOW_DROP_CNT_EN.
- Defined:
  - `drop_count` port exists.
  - Increments by 1 on each dropped window and saturates at 255.
  - Cleared only by rst.
- Undefined: port absent; dropped windows are lost silently and all other behaviour is identical.

## Test plan
All scenarios use WINDOW=8, DEPTH=4.
- Reset, out_ready=1, a = 1,1,0,0,1,1,1,1 -> out_valid = 1 for exactly one cycle, starting the cycle after the 8th sample, with out_count = 6.
- Three windows: all-1, all-0, then 1,0,1,0,1,0,1,0, with out_ready=1 -> counts 8, 0, 4 in order, each valid for one cycle.
- out_ready=0, six all-1 windows -> out_valid stays 1 with 4 entries held; drop_count = 2 (macro on). Then out_ready=1 -> 8,8,8,8 on four consecutive cycles, then out_valid = 0.
- FIFO full; raise out_ready exactly on a window-close cycle -> head popped, new window result pushed, drop_count unchanged, occupancy stays 4.
- Two entries queued and 3 tokens into the current window; assert rst for one cycle -> out_valid = 0 the next cycle, and the next window (8 ones) yields exactly 8.
- Macro on: 300 overflowing windows with out_ready=0 -> drop_count saturates at 255 and does not wrap.
